// File: rtl/operand_issue_stage_pkg.sv
// Shared instruction-class encodings and forwarding widths for the ID/EX
// operand issue stage.
package operand_issue_stage_pkg;

   localparam int FWD_RD_W = 5;

   typedef logic [3:0] ir_type_t;

   localparam ir_type_t LUI_IR      = 4'd0;
   localparam ir_type_t AUIPC_IR    = 4'd1;
   localparam ir_type_t JAL_IR      = 4'd2;
   localparam ir_type_t JALR_IR     = 4'd3;
   localparam ir_type_t BRANCH_IR   = 4'd4;
   localparam ir_type_t LOAD_IR     = 4'd5;
   localparam ir_type_t STORE_IR    = 4'd6;
   localparam ir_type_t REG_IMM_IR  = 4'd7;
   localparam ir_type_t REG_REG_IR  = 4'd8;
   localparam ir_type_t SYS_CALL_IR = 4'd9;
   localparam ir_type_t CSR_IR      = 4'd10;

endpackage

// File: rtl/operand_issue_stage_if.sv
// Decoder-side and EX-side signals of the operand issue stage; the stage
// itself connects through the slave modport.
interface operand_issue_stage_if #(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 2,
   parameter int CNT_W   = 16
);
   import operand_issue_stage_pkg::*;

   logic                         in_valid;
   logic                         in_ready;
   logic [3:0]                   ir_type;
   logic [2:0]                   funct3;
   logic [FWD_RD_W-1:0]          rs1;
   logic [FWD_RD_W-1:0]          rs2;
   logic [XLEN-1:0]              data1;
   logic [XLEN-1:0]              data2;
   logic [XLEN-1:0]              pc;
   logic [XLEN-1:0]              imm;
   logic [XLEN-1:0]              z_;
   logic [NUM_FWD-1:0]           fwd_valid;
   logic [NUM_FWD-1:0]           fwd_pending;
   logic [FWD_RD_W*NUM_FWD-1:0]  fwd_rd;
   logic [XLEN*NUM_FWD-1:0]      fwd_data;
   logic                         flush;
   logic                         out_valid;
   logic                         out_ready;
   logic [XLEN-1:0]              in1;
   logic [XLEN-1:0]              in2;
   logic [XLEN-1:0]              store_data;
   logic [3:0]                   out_ir_type;
   logic [2:0]                   out_funct3;
   logic [CNT_W-1:0]             stall_cnt;

   modport master (
      output in_valid, ir_type, funct3, rs1, rs2, data1, data2, pc, imm, z_,
             fwd_valid, fwd_pending, fwd_rd, fwd_data, flush, out_ready,
      input  in_ready, out_valid, in1, in2, store_data, out_ir_type,
             out_funct3, stall_cnt
   );

   modport slave (
      input  in_valid, ir_type, funct3, rs1, rs2, data1, data2, pc, imm, z_,
             fwd_valid, fwd_pending, fwd_rd, fwd_data, flush, out_ready,
      output in_ready, out_valid, in1, in2, store_data, out_ir_type,
             out_funct3, stall_cnt
   );

endinterface

// File: rtl/operand_issue_stage_fwd_select.sv
// Resolves one source operand: youngest matching forwarding source wins,
// register file otherwise, x0 always reads as zero and never pends.
module fwd_select
   import operand_issue_stage_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 2
) (
   input  logic [FWD_RD_W-1:0]         i_rs,
   input  logic [XLEN-1:0]             i_rf_data,
   input  logic [NUM_FWD-1:0]          i_fwd_valid,
   input  logic [NUM_FWD-1:0]          i_fwd_pending,
   input  logic [FWD_RD_W*NUM_FWD-1:0] i_fwd_rd,
   input  logic [XLEN*NUM_FWD-1:0]     i_fwd_data,
   output logic [XLEN-1:0]             o_data,
   output logic                        o_pending
);

   logic [NUM_FWD-1:0] w_hit;
   logic [XLEN-1:0]    w_src_data [NUM_FWD];

   generate
      for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_src
         assign w_hit[gi] = i_fwd_valid[gi] &&
                            (i_fwd_rd[gi*FWD_RD_W +: FWD_RD_W] == i_rs);
         assign w_src_data[gi] = i_fwd_data[gi*XLEN +: XLEN];
      end
   endgenerate

   // Walk from oldest to youngest so the lowest matching index is left standing.
   always_comb begin
      o_data    = i_rf_data;
      o_pending = 1'b0;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            o_data    = w_src_data[i];
            o_pending = i_fwd_pending[i];
         end
      end
      if (i_rs == '0) begin
         o_data    = '0;
         o_pending = 1'b0;
      end
   end

endmodule

// File: rtl/operand_issue_stage.sv
// Registered ID/EX operand stage: forwarding, load-use stall, ALU operand
// selection and a one-entry valid/ready register towards EX.
module operand_issue_stage
   import operand_issue_stage_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 2,
   parameter int CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   operand_issue_stage_if.slave  bus
);

   logic [XLEN-1:0]   w_r1;
   logic [XLEN-1:0]   w_r2;
   logic              w_pend1;
   logic              w_pend2;
   logic              w_hazard;
   logic              w_in_ready;
   logic              w_capture;
   logic [XLEN-1:0]   w_in1;
   logic [XLEN-1:0]   w_in2;

   logic              r_out_valid;
   logic [XLEN-1:0]   r_in1;
   logic [XLEN-1:0]   r_in2;
   logic [XLEN-1:0]   r_store_data;
   logic [3:0]        r_ir_type;
   logic [2:0]        r_funct3;
   logic [CNT_W-1:0]  r_stall_cnt;

   function automatic logic uses_rs1(input logic [3:0] ir, input logic [2:0] f3);
      case (ir)
         JALR_IR, BRANCH_IR, LOAD_IR, STORE_IR, REG_IMM_IR, REG_REG_IR: uses_rs1 = 1'b1;
         CSR_IR:  uses_rs1 = ~f3[2];
         default: uses_rs1 = 1'b0;
      endcase
   endfunction

   function automatic logic uses_rs2(input logic [3:0] ir);
      case (ir)
         BRANCH_IR, STORE_IR, REG_REG_IR: uses_rs2 = 1'b1;
         default:                         uses_rs2 = 1'b0;
      endcase
   endfunction

   // Returns {in1, in2}.
   function automatic logic [2*XLEN-1:0] select_operands(
      input logic [3:0]      ir,
      input logic [2:0]      f3,
      input logic [XLEN-1:0] r1,
      input logic [XLEN-1:0] r2,
      input logic [XLEN-1:0] pc,
      input logic [XLEN-1:0] imm,
      input logic [XLEN-1:0] z
   );
      case (ir)
         LUI_IR, AUIPC_IR, JAL_IR, BRANCH_IR:        select_operands = {pc, imm};
         JALR_IR, LOAD_IR, STORE_IR, REG_IMM_IR:     select_operands = {r1, imm};
         REG_REG_IR:                                 select_operands = {r1, r2};
         SYS_CALL_IR:                                select_operands = {z, imm};
         CSR_IR:  select_operands = f3[2] ? {z, imm} : {z, r1};
         default:                                    select_operands = {r1, r2};
      endcase
   endfunction

   fwd_select #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
      .i_rs          (bus.rs1),
      .i_rf_data     (bus.data1),
      .i_fwd_valid   (bus.fwd_valid),
      .i_fwd_pending (bus.fwd_pending),
      .i_fwd_rd      (bus.fwd_rd),
      .i_fwd_data    (bus.fwd_data),
      .o_data        (w_r1),
      .o_pending     (w_pend1)
   );

   fwd_select #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
      .i_rs          (bus.rs2),
      .i_rf_data     (bus.data2),
      .i_fwd_valid   (bus.fwd_valid),
      .i_fwd_pending (bus.fwd_pending),
      .i_fwd_rd      (bus.fwd_rd),
      .i_fwd_data    (bus.fwd_data),
      .o_data        (w_r2),
      .o_pending     (w_pend2)
   );

   // A pending source only matters for an operand the class actually reads.
   assign w_hazard = (uses_rs1(bus.ir_type, bus.funct3) && w_pend1) ||
                     (uses_rs2(bus.ir_type) && w_pend2);

   assign w_in_ready = bus.flush || (!w_hazard && (!r_out_valid || bus.out_ready));
   assign w_capture  = bus.in_valid && w_in_ready && !bus.flush;

   assign {w_in1, w_in2} = select_operands(bus.ir_type, bus.funct3, w_r1, w_r2,
                                           bus.pc, bus.imm, bus.z_);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_in1        <= '0;
         r_in2        <= '0;
         r_store_data <= '0;
         r_ir_type    <= '0;
         r_funct3     <= '0;
      end else if (bus.flush) begin
         r_out_valid <= 1'b0;
      end else if (w_capture) begin
         r_out_valid  <= 1'b1;
         r_in1        <= w_in1;
         r_in2        <= w_in2;
         r_store_data <= w_r2;
         r_ir_type    <= bus.ir_type;
         r_funct3     <= bus.funct3;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_hazard && bus.in_valid && !bus.flush && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = r_out_valid;
   assign bus.in1         = r_in1;
   assign bus.in2         = r_in2;
   assign bus.store_data  = r_store_data;
   assign bus.out_ir_type = r_ir_type;
   assign bus.out_funct3  = r_funct3;
   assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: doc/operand_issue_stage.md
# operand_issue_stage

Registered ID/EX operand stage, successor to the combinational ALU-input selector. Resolves rs1/rs2 operand values through a parametrised set of forwarding sources, detects load-use hazards and stalls, selects ALU `in1`/`in2` per instruction class, and presents them to EX through a one-entry valid/ready pipeline register with flush. Sits between the decoder/register file and the EX stage; also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- `XLEN`, 32, datapath width
- `NUM_FWD`, 2, number of forwarding sources; index 0 is the youngest and has the highest priority
- `CNT_W`, 16, stall counter width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  decoded instruction present
- `in_ready`  out  1  stage accepts the instruction this cycle
- `ir_type`  in  4  instruction class, encoded with the shared `*_IR` constants
- `funct3`  in  3  instruction funct3 field
- `rs1`, `rs2`  in  5 each  source register indices
- `data1`, `data2`  in  XLEN each  register-file read data
- `pc`, `imm`, `z_`  in  XLEN each  PC, immediate, CSR/system operand
- `fwd_valid`  in  NUM_FWD  source i holds a register write
- `fwd_pending`  in  NUM_FWD  source i's data is not yet available (load in flight)
- `fwd_rd`  in  5*NUM_FWD  destination of source i, packed as bits [5i+4:5i]
- `fwd_data`  in  XLEN*NUM_FWD  result of source i, packed likewise
- `flush`  in  1  kill the held entry and the incoming instruction
- `out_valid`  out  1  EX entry valid
- `out_ready`  in  1  EX consumes the entry
- `in1`, `in2`  out  XLEN each  ALU operands
- `store_data`  out  XLEN  resolved rs2 value, used by store and branch
- `out_ir_type`  out  4  registered `ir_type`
- `out_funct3`  out  3  registered `funct3`
- `stall_cnt`  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- **rs1 use:** JALR, BRANCH, LOAD, STORE, REG_IMM, REG_REG, and CSR when `funct3[2]==0`.
- **rs2 use:** BRANCH, STORE, REG_REG.
- **Forwarding per operand:**
  - Choose the lowest i with `fwd_valid[i]`, `fwd_rd_i==rs`, and `rs!=0`.
  - Otherwise use the register-file data.
  - rs==0 always resolves to 0.
- **Hazard:** set when a used operand's selected source has `fwd_pending[i]==1`. While hazard is set: `in_ready=0`, nothing is captured, and `stall_cnt` increments (saturating at all-ones) when `in_valid`.
- **Operand selection, using resolved r1/r2:**
  - LUI, AUIPC, JAL, BRANCH: {pc, imm}
  - JALR, LOAD, STORE, REG_IMM: {r1, imm}
  - REG_REG: {r1, r2}
  - SYS_CALL: {z_, imm}
  - CSR: {z_, imm} when `funct3[2]`, else {z_, r1}
  - default: {r1, r2}
- `store_data` = r2 for every class.
- **Handshake:**
  - `in_ready = !hazard && (!out_valid || out_ready)`, or `in_ready=1` during `flush`.
  - Capture happens on `in_valid && in_ready && !flush`.
- **Flush** has priority over capture and hold. Next cycle `out_valid=0`; the incoming beat is discarded.

## Timing
- **Reset:** `out_valid=0`; `in1`, `in2`, `store_data`, `out_ir_type`, `out_funct3`, and `stall_cnt` are all 0.
- **Latency:** 1 cycle from accepted input to `out_valid`.
- **Back-pressure:** while `out_valid && !out_ready`, all outputs hold stable and `in_ready=0`.
- **Back-to-back:** `out_valid && out_ready && in_valid` with no hazard loads the new entry the same edge, sustaining full throughput.
- **Stall:** the hazard is evaluated combinationally each cycle. The instruction issues on the first cycle the pending bit clears, using the forwarded value from that cycle.
- **Priority:** simultaneous flush and `out_ready` leaves the stage empty. `stall_cnt` does not count during flush.
- **Reset mid-stall:** the entry is cleared and the counter zeroed.

## Structure
- `*_IR` encodings stay in the shared `constants/ir_type.v` package; add `FWD_RD_W=5` there.
- Sub-module `fwd_select`, instantiated once per operand. It takes `rs`, `rf_data` and the packed forwarding buses, and returns `data` and `pending`.
- The use-decode and operand-selection functions live in this module.

## Test plan
- **REG_REG, no forwarding:** rs1=3 (data1=0x10), rs2=4 (data2=0x20) -> next cycle `out_valid=1`, in1=0x10, in2=0x20.
- **Priority:** `fwd_valid=2'b11`, `fwd_rd` both 3, `fwd_data[0]=0xAA`, `fwd_data[1]=0xBB`, REG_IMM rs1=3, imm=5 -> in1=0xAA, in2=5. With rs1=0 -> in1=0.
- **Load-use:** `fwd_pending[0]=1`, rd=7, STORE rs2=7 for 3 cycles -> `in_ready=0` for 3 cycles, `stall_cnt=3`. When pending clears with `fwd_data=0x55` -> `store_data=0x55`.
- **Back-pressure:** `out_ready=0` for 4 cycles with a new `in_valid` -> outputs unchanged, `in_ready=0`. Raising `out_ready` -> the next instruction loads on that edge.
- **Flush:** flush while `out_valid=1` and `in_valid=1` -> `out_valid=0` next cycle and neither instruction appears.
- **CSR:** `funct3=3'b101`, imm=0x1F -> {z_, 0x1F}. `funct3=3'b001`, rs1 forwarded 0x9 -> {z_, 0x9}.
